data_memory_sized: RTL and testbench

- Parametrised successor to the single-cycle word data memory used by the MIPS datapath. Adds byte, halfword and word accesses with sign or zero extension, a configurable base address and depth, a registered read path with a valid strobe, and address-fault detection that captures the first faulting address.
- Sits between the ALU address output and the write-back mux. It serves lb/lbu/lh/lhu/lw/sb/sh/sw.

---
 rtl/data_memory_sized.sv | 154 +++++++++++++++
 tb/tb_data_memory_sized.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/data_memory_sized.sv
// Byte/half/word data memory for the MIPS datapath: sign/zero-extended loads with a
// registered read path, byte-enable stores, and sticky capture of the first faulting address.
module data_memory_sized #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          MEMORY_DEPTH = 1024,
  parameter logic [31:0] BASE_ADDRESS = 32'h1001_0000,
  localparam int         ADDR_WIDTH   = $clog2(MEMORY_DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  output logic [31:0] ReadData,
  output logic        ReadValid,
  output logic        AddrError,
  output logic [31:0] ErrorAddress
);

  localparam logic [31:0] DEPTH_LIMIT = 32'(MEMORY_DEPTH);

  generate
    if (DATA_WIDTH != 32) begin : g_width_check
      $error("data_memory_sized: DATA_WIDTH must be 32");
    end
    if ((MEMORY_DEPTH < 2) || ((MEMORY_DEPTH & (MEMORY_DEPTH - 1)) != 0)) begin : g_depth_check
      $error("data_memory_sized: MEMORY_DEPTH must be a power of two");
    end
  endgenerate

  // Pulls the addressed byte/half out of a word and extends it to 32 bits.
  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic zero_ext);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] result_v;
    byte_v = word[{lane, 3'b000} +: 8];
    half_v = word[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   result_v = zero_ext ? {24'h000000, byte_v} : {{24{byte_v[7]}}, byte_v};
      2'b01:   result_v = zero_ext ? {16'h0000, half_v} : {{16{half_v[15]}}, half_v};
      2'b10:   result_v = word;
      default: result_v = 32'h0000_0000;
    endcase
    return result_v;
  endfunction

  logic [31:0]           mem_r [MEMORY_DEPTH];
  logic [31:0]           offset_s;
  logic [ADDR_WIDTH-1:0] index_s;
  logic [1:0]            lane_s;
  logic [31:0]           rword_s;
  logic                  out_of_range_s;
  logic                  misaligned_s;
  logic                  size_fault_s;
  logic                  fault_s;
  logic                  do_write_s;
  logic                  do_read_s;
  logic [3:0]            byte_en_s;
  logic [31:0]           wdata_s;
  logic [31:0]           load_value_s;
  logic [31:0]           read_data_r;
  logic                  read_valid_r;
  logic                  addr_error_r;
  logic [31:0]           error_address_r;

  assign offset_s     = Address - BASE_ADDRESS;
  assign index_s      = offset_s[ADDR_WIDTH+1:2];
  assign lane_s       = offset_s[1:0];
  assign rword_s      = mem_r[index_s];
  assign load_value_s = extend_load(rword_s, lane_s, Size, Unsigned);

  // Fault classification and request qualification.
  always_comb begin
    misaligned_s = 1'b0;
    size_fault_s = 1'b0;
    case (Size)
      2'b00:   misaligned_s = 1'b0;
      2'b01:   misaligned_s = lane_s[0];
      2'b10:   misaligned_s = (lane_s != 2'b00);
      default: size_fault_s = 1'b1;
    endcase
    // Full 30-bit word offset is compared so addresses past the top never alias onto low words.
    out_of_range_s = (Address < BASE_ADDRESS) || ({2'b00, offset_s[31:2]} >= DEPTH_LIMIT);
    fault_s        = (MemRead | MemWrite) & (out_of_range_s | misaligned_s | size_fault_s);
    do_write_s     = MemWrite & ~fault_s & ~reset;
    do_read_s      = MemRead & ~MemWrite & ~fault_s;
  end

  // Store lane enables with the store value replicated across all lanes.
  always_comb begin
    byte_en_s = 4'b0000;
    wdata_s   = WriteData;
    case (Size)
      2'b00: begin
        byte_en_s = 4'b0001 << lane_s;
        wdata_s   = {4{WriteData[7:0]}};
      end
      2'b01: begin
        byte_en_s = lane_s[1] ? 4'b1100 : 4'b0011;
        wdata_s   = {2{WriteData[15:0]}};
      end
      2'b10: begin
        byte_en_s = 4'b1111;
        wdata_s   = WriteData;
      end
      default: begin
        byte_en_s = 4'b0000;
        wdata_s   = WriteData;
      end
    endcase
  end

  // Byte-lane RAM write port; contents are deliberately not touched by reset.
  always_ff @(posedge clk) begin
    if (do_write_s) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en_s[i]) begin
          mem_r[index_s][8*i +: 8] <= wdata_s[8*i +: 8];
        end
      end
    end
  end

  // Registered load result, valid strobe and sticky first-fault capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data_r     <= 32'h0000_0000;
      read_valid_r    <= 1'b0;
      addr_error_r    <= 1'b0;
      error_address_r <= 32'h0000_0000;
    end else begin
      read_valid_r <= do_read_s;
      if (do_read_s) begin
        read_data_r <= load_value_s;
      end
      if (fault_s) begin
        addr_error_r <= 1'b1;
        if (!addr_error_r) begin
          error_address_r <= Address;
        end
      end
    end
  end

  assign ReadData     = read_data_r;
  assign ReadValid    = read_valid_r;
  assign AddrError    = addr_error_r;
  assign ErrorAddress = error_address_r;

endmodule

// File: tb/tb_data_memory_sized.sv
// Scoreboard bench for data_memory_sized: expected load results are queued with their due
// cycle when a load is driven and matched against ReadValid/ReadData by a negedge monitor.
module tb_data_memory_sized;

  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam logic [1:0]  SZ_B = 2'b00;
  localparam logic [1:0]  SZ_H = 2'b01;
  localparam logic [1:0]  SZ_W = 2'b10;
  localparam logic [1:0]  SZ_X = 2'b11;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [1:0]  Size;
  logic        Unsigned;
  logic [31:0] ReadData;
  logic        ReadValid;
  logic        AddrError;
  logic [31:0] ErrorAddress;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  data_memory_sized dut (
    .clk          (clk),
    .reset        (reset),
    .Address      (Address),
    .WriteData    (WriteData),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .Size         (Size),
    .Unsigned     (Unsigned),
    .ReadData     (ReadData),
    .ReadValid    (ReadValid),
    .AddrError    (AddrError),
    .ErrorAddress (ErrorAddress)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one request for a single clock; queue the expected load result when one is due.
  task automatic op(input logic w, input logic r, input logic [1:0] sz, input logic uns,
                    input logic [31:0] a, input logic [31:0] d,
                    input logic push, input logic [31:0] exp);
    exp_t e;
    MemWrite  = w;
    MemRead   = r;
    Size      = sz;
    Unsigned  = uns;
    Address   = a;
    WriteData = d;
    if (push) begin
      e.data = exp;
      e.due  = cyc + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    MemWrite = 1'b0;
    MemRead  = 1'b0;
  endtask

  // Output monitor: a due entry must see ReadValid with matching data, otherwise ReadValid stays low.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        check_value("read_valid", {31'b0, ReadValid}, 32'd1);
        check_value("read_data", ReadData, exp_q[0].data);
        void'(exp_q.pop_front());
      end else begin
        check_value("no_valid", {31'b0, ReadValid}, 32'd0);
      end
    end
  end

  initial begin
    reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0; Size = SZ_W; Unsigned = 1'b0;
    Address = BASE; WriteData = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_value("rst_rdata", ReadData, 32'h0);
    check_value("rst_valid", {31'b0, ReadValid}, 32'd0);
    check_value("rst_err", {31'b0, AddrError}, 32'd0);
    check_value("rst_eaddr", ErrorAddress, 32'h0);
    mon_en = 1'b1;

    // Word store then load (read-after-write next cycle)
    op(1, 0, SZ_W, 0, BASE + 32'h4, 32'hDEADBEEF, 0, 32'h0);
    op(0, 1, SZ_W, 0, BASE + 32'h4, 32'h0, 1, 32'hDEADBEEF);

    // Byte store into a cleared word; only WriteData[7:0] may land
    op(1, 0, SZ_W, 0, BASE + 32'h8, 32'h0, 0, 32'h0);
    op(1, 0, SZ_B, 0, BASE + 32'h9, 32'h12345680, 0, 32'h0);
    op(0, 1, SZ_B, 0, BASE + 32'h9, 32'h0, 1, 32'hFFFFFF80);
    op(0, 1, SZ_B, 1, BASE + 32'h9, 32'h0, 1, 32'h00000080);
    op(0, 1, SZ_W, 1, BASE + 32'h8, 32'h0, 1, 32'h00008000);

    // Halfword store over a preloaded word
    op(1, 0, SZ_W, 0, BASE + 32'h10, 32'h11223344, 0, 32'h0);
    op(1, 0, SZ_H, 0, BASE + 32'h12, 32'h5A5AA5A5, 0, 32'h0);
    op(0, 1, SZ_W, 0, BASE + 32'h10, 32'h0, 1, 32'hA5A53344);
    op(0, 1, SZ_H, 0, BASE + 32'h12, 32'h0, 1, 32'hFFFFA5A5);
    op(0, 1, SZ_H, 1, BASE + 32'h10, 32'h0, 1, 32'h00003344);
    op(0, 1, SZ_B, 0, BASE + 32'h13, 32'h0, 1, 32'hFFFFFFA5);

    // Faults: misaligned load captured, later faults leave ErrorAddress alone
    op(1, 0, SZ_W, 0, BASE, 32'hCAFEF00D, 0, 32'h0);
    check_value("no_err_yet", {31'b0, AddrError}, 32'd0);
    op(0, 1, SZ_W, 0, BASE + 32'h2, 32'h0, 0, 32'h0);
    check_value("err_set", {31'b0, AddrError}, 32'd1);
    check_value("err_addr1", ErrorAddress, 32'h10010002);
    op(1, 0, SZ_W, 0, 32'h0FFFFFFC, 32'h99999999, 0, 32'h0);
    check_value("err_addr_kept", ErrorAddress, 32'h10010002);
    op(0, 1, SZ_X, 0, BASE, 32'h0, 0, 32'h0);
    op(1, 0, SZ_H, 0, BASE + 32'h11, 32'hFFFFFFFF, 0, 32'h0);
    op(1, 0, SZ_X, 0, BASE + 32'h10, 32'hFFFFFFFF, 0, 32'h0);
    check_value("err_sticky", {31'b0, AddrError}, 32'd1);
    op(0, 1, SZ_W, 0, BASE, 32'h0, 1, 32'hCAFEF00D);
    op(0, 1, SZ_W, 0, BASE + 32'h10, 32'h0, 1, 32'hA5A53344);

    // Reset clears outputs and fault state
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_value("rst2_rdata", ReadData, 32'h0);
    check_value("rst2_err", {31'b0, AddrError}, 32'd0);
    check_value("rst2_eaddr", ErrorAddress, 32'h0);

    // Depth boundary: last word legal, one past faults without aliasing to word 0
    op(1, 0, SZ_W, 0, BASE + 32'd4092, 32'h0BADC0DE, 0, 32'h0);
    op(0, 1, SZ_W, 0, BASE + 32'd4092, 32'h0, 1, 32'h0BADC0DE);
    check_value("edge_no_err", {31'b0, AddrError}, 32'd0);
    op(1, 0, SZ_W, 0, BASE + 32'd4096, 32'h55555555, 0, 32'h0);
    check_value("edge_err", {31'b0, AddrError}, 32'd1);
    check_value("edge_eaddr", ErrorAddress, BASE + 32'd4096);
    op(0, 1, SZ_W, 0, BASE + 32'd4096, 32'h0, 0, 32'h0);
    op(0, 1, SZ_W, 0, BASE, 32'h0, 1, 32'hCAFEF00D);

    // Simultaneous read+write behaves as a store only
    op(1, 1, SZ_W, 0, BASE + 32'h20, 32'h77665544, 0, 32'h0);
    check_value("rw_no_valid", {31'b0, ReadValid}, 32'd0);
    op(0, 1, SZ_W, 0, BASE + 32'h20, 32'h0, 1, 32'h77665544);

    // Reset coincident with a load squashes it
    reset = 1'b1;
    op(0, 1, SZ_W, 0, BASE + 32'h20, 32'h0, 0, 32'h0);
    reset = 1'b0;
    check_value("rst_load_valid", {31'b0, ReadValid}, 32'd0);
    check_value("rst_load_rdata", ReadData, 32'h0);
    check_value("rst_load_err", {31'b0, AddrError}, 32'd0);

    repeat (3) @(negedge clk);
    check_value("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
